perf_monitor: RTL and testbench

Clocked, parametrised successor to the latch-based instruction/stall/arithmetic/memory counters in the control decoder.
- Takes the same decode fields (instruction_type, opcode) qualified by a valid strobe and classifies each accepted instruction.
- Maintains a bank of 8 event counters with sticky overflow flags, wrap or saturate mode, freeze/clear controls and an atomic snapshot.
- Counters are read back through a registered read port.
- Sits beside control_unit in decode; software and the testbench read it via the debug bus.

---
 rtl/perf_pkg.sv | 35 +++
 rtl/perf_counter.sv | 37 +++
 rtl/perf_monitor.sv | 96 +++++++++
 tb/tb_perf_monitor.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/perf_pkg.sv
// Shared constants for the decode-stage performance monitor.
// Latency: n/a (package).
// Backpressure: n/a (package).
package perf_pkg;

    localparam int NUM_CNT = 8;

    // Counter bank index map
    typedef enum logic [2:0] {
        CNT_INSTR   = 3'd0,
        CNT_ARITH   = 3'd1,
        CNT_MEM     = 3'd2,
        CNT_STALL   = 3'd3,
        CNT_CTRL    = 3'd4,
        CNT_VEC     = 3'd5,
        CNT_ILLEGAL = 3'd6,
        CNT_CYCLE   = 3'd7
    } cnt_idx_e;

    // Decode instruction classes
    localparam logic [1:0] TYPE_MEM  = 2'b00;
    localparam logic [1:0] TYPE_DATA = 2'b01;
    localparam logic [1:0] TYPE_CTRL = 2'b10;
    localparam logic [1:0] TYPE_VEC  = 2'b11;

    // Data-class opcodes that represent pipeline stalls
    localparam logic [4:0] STALL_OP0 = 5'b00101;
    localparam logic [4:0] STALL_OP1 = 5'b00110;
    localparam logic [4:0] STALL_OP2 = 5'b00111;

    function automatic logic is_stall(input logic [4:0] op);
        return (op == STALL_OP0) || (op == STALL_OP1) || (op == STALL_OP2);
    endfunction

endpackage

// File: rtl/perf_counter.sv
// Single event counter with sticky overflow, wrap or saturate at max.
// Latency: an inc in cycle N is visible in cnt after the edge closing cycle N.
// Backpressure: none; clr beats frz beats inc.
// Ports: clk, rst (async high), inc/clr/frz controls, cnt value, ovf sticky flag.
module perf_counter #(
    parameter int CNT_W    = 19,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    input  logic             frz,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (!frz && inc) begin
            if (cnt == CNT_MAX) begin
                ovf <= 1'b1;
                cnt <= (SATURATE != 0) ? CNT_MAX : '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/perf_monitor.sv
// Decode-stage performance monitor: classifies accepted instructions into 8 counters,
// Latency: counters update one edge after the event; rd_data/rd_valid one cycle after rd_en.
// Backpressure: none; one instruction and one read per cycle, freeze holds counters only.
// Ports: clk, rst; in_valid/instruction_type/opcode decode fields; freeze/clear/snap
//        controls; rd_en/rd_sel read request; rd_data/rd_valid read result; ovf flags.
module perf_monitor
    import perf_pkg::*;
#(
    parameter int CNT_W    = 19,
    parameter int SATURATE = 0,
    parameter int CYCLE_EN = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [1:0]          instruction_type,
    input  logic [4:0]          opcode,
    input  logic                freeze,
    input  logic                clear,
    input  logic                snap,
    input  logic                rd_en,
    input  logic [2:0]          rd_sel,
    output logic [CNT_W-1:0]    rd_data,
    output logic                rd_valid,
    output logic [NUM_CNT-1:0]  ovf
);

    logic [NUM_CNT-1:0] inc;
    logic [CNT_W-1:0]   live   [NUM_CNT];
    logic [CNT_W-1:0]   shadow [NUM_CNT];

    // Classifier: every decode combination maps to a defined set of events.
    always_comb begin
        inc = '0;
        if (in_valid) begin
            inc[CNT_INSTR] = 1'b1;
            case (instruction_type)
                TYPE_MEM:  inc[CNT_MEM]  = 1'b1;
                TYPE_CTRL: inc[CNT_CTRL] = 1'b1;
                TYPE_VEC: begin
                    inc[CNT_ARITH] = 1'b1;
                    inc[CNT_VEC]   = 1'b1;
                end
                TYPE_DATA: begin
                    // Upper half is arithmetic; 01xxx is unused; 00101-00111 are stalls.
                    if (opcode[4])
                        inc[CNT_ARITH] = 1'b1;
                    else if (opcode[3])
                        inc[CNT_ILLEGAL] = 1'b1;
                    else if (is_stall(opcode))
                        inc[CNT_STALL] = 1'b1;
                    else
                        inc[CNT_ARITH] = 1'b1;
                end
            endcase
        end
        inc[CNT_CYCLE] = (CYCLE_EN != 0);
    end

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        perf_counter #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE)
        ) u_cnt (
            .clk (clk),
            .rst (rst),
            .inc (inc[g]),
            .clr (clear),
            .frz (freeze),
            .cnt (live[g]),
            .ovf (ovf[g])
        );
    end

    // Shadows sample the live registers before this edge's update, so a snap
    // alongside clear or an increment captures the old values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CNT; i++) shadow[i] <= '0;
        end else if (snap) begin
            for (int i = 0; i < NUM_CNT; i++) shadow[i] <= live[i];
        end
    end

    // Read port sees the shadow value from before any same-cycle snap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_data <= shadow[rd_sel];
        end
    end

endmodule

// File: tb/tb_perf_monitor.sv
// Self-checking bench: three monitor configurations share one stimulus stream
// and are compared every cycle against an event-level model, plus literal checks.
module tb_perf_monitor;

    localparam int ND = 3;
    localparam int MW [ND] = '{19, 4, 4};
    localparam int MS [ND] = '{0, 0, 1};
    localparam int MC [ND] = '{1, 1, 0};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [1:0]  instruction_type = '0;
    logic [4:0]  opcode = '0;
    logic        freeze = 1'b0;
    logic        clear = 1'b0;
    logic        snap = 1'b0;
    logic        rd_en = 1'b0;
    logic [2:0]  rd_sel = '0;

    logic [18:0] rd_data0;
    logic [3:0]  rd_data1, rd_data2;
    logic        rd_valid0, rd_valid1, rd_valid2;
    logic [7:0]  ovf0, ovf1, ovf2;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    perf_monitor #(.CNT_W(19), .SATURATE(0), .CYCLE_EN(1)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instruction_type(instruction_type),
        .opcode(opcode), .freeze(freeze), .clear(clear), .snap(snap), .rd_en(rd_en),
        .rd_sel(rd_sel), .rd_data(rd_data0), .rd_valid(rd_valid0), .ovf(ovf0));
    perf_monitor #(.CNT_W(4), .SATURATE(0), .CYCLE_EN(1)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instruction_type(instruction_type),
        .opcode(opcode), .freeze(freeze), .clear(clear), .snap(snap), .rd_en(rd_en),
        .rd_sel(rd_sel), .rd_data(rd_data1), .rd_valid(rd_valid1), .ovf(ovf1));
    perf_monitor #(.CNT_W(4), .SATURATE(1), .CYCLE_EN(0)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .instruction_type(instruction_type),
        .opcode(opcode), .freeze(freeze), .clear(clear), .snap(snap), .rd_en(rd_en),
        .rd_sel(rd_sel), .rd_data(rd_data2), .rd_valid(rd_valid2), .ovf(ovf2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_live [ND][8];
    int         m_sh   [ND][8];
    logic [7:0] m_ovf  [ND];
    int         m_rd   [ND];
    logic       m_rv   [ND];

    // Which of counters 0..6 an accepted instruction touches.
    function automatic logic [7:0] events(input logic v, input logic [1:0] t, input logic [4:0] op);
        logic [7:0] e;
        int o;
        e = 8'h00;
        o = int'(op);
        if (v) begin
            e[0] = 1'b1;
            if (t == 2'b00) e[2] = 1'b1;
            else if (t == 2'b10) e[4] = 1'b1;
            else if (t == 2'b11) begin e[1] = 1'b1; e[5] = 1'b1; end
            else begin
                if (o <= 4 || o >= 16) e[1] = 1'b1;
                else if (o <= 7)       e[3] = 1'b1;
                else                   e[6] = 1'b1;
            end
        end
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < ND; d++) begin
                for (int i = 0; i < 8; i++) begin m_live[d][i] = 0; m_sh[d][i] = 0; end
                m_ovf[d] = 8'h00; m_rd[d] = 0; m_rv[d] = 1'b0;
            end
        end else begin
            logic [7:0] ev;
            ev = events(in_valid, instruction_type, opcode);
            for (int d = 0; d < ND; d++) begin
                int mx;
                mx = (1 << MW[d]) - 1;
                m_rv[d] = rd_en;
                if (rd_en) m_rd[d] = m_sh[d][rd_sel];
                if (snap) for (int i = 0; i < 8; i++) m_sh[d][i] = m_live[d][i];
                if (clear) begin
                    for (int i = 0; i < 8; i++) m_live[d][i] = 0;
                    m_ovf[d] = 8'h00;
                end else if (!freeze) begin
                    for (int i = 0; i < 8; i++) begin
                        if (ev[i] || (i == 7 && MC[d] != 0)) begin
                            if (m_live[d][i] == mx) begin
                                m_ovf[d][i] = 1'b1;
                                m_live[d][i] = (MS[d] != 0) ? mx : 0;
                            end else begin
                                m_live[d][i] = m_live[d][i] + 1;
                            end
                        end
                    end
                end
            end
        end
    end

    // Per-cycle compare of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("dut0 rd_valid", 32'(rd_valid0), 32'(m_rv[0]));
            check("dut1 rd_valid", 32'(rd_valid1), 32'(m_rv[1]));
            check("dut2 rd_valid", 32'(rd_valid2), 32'(m_rv[2]));
            check("dut0 rd_data",  32'(rd_data0),  32'(m_rd[0]));
            check("dut1 rd_data",  32'(rd_data1),  32'(m_rd[1]));
            check("dut2 rd_data",  32'(rd_data2),  32'(m_rd[2]));
            check("dut0 ovf",      32'(ovf0),      32'(m_ovf[0]));
            check("dut1 ovf",      32'(ovf1),      32'(m_ovf[1]));
            check("dut2 ovf",      32'(ovf2),      32'(m_ovf[2]));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input logic v, input logic [1:0] t, input logic [4:0] op,
                        input logic fr, input logic cl, input logic sn,
                        input logic re, input logic [2:0] sel);
        @(negedge clk);
        #1;
        in_valid = v; instruction_type = t; opcode = op;
        freeze = fr; clear = cl; snap = sn; rd_en = re; rd_sel = sel;
    endtask

    task automatic idle();            tick(0, 2'b00, 5'd0, 0, 0, 0, 0, 3'd0); endtask
    task automatic instr(input logic [1:0] t, input logic [4:0] op); tick(1, t, op, 0, 0, 0, 0, 3'd0); endtask
    task automatic do_clear();        tick(0, 2'b00, 5'd0, 0, 1, 0, 0, 3'd0); endtask
    task automatic do_snap();         tick(0, 2'b00, 5'd0, 0, 0, 1, 0, 3'd0); endtask

    task automatic rd_chk(input logic [2:0] sel, input int exp, input string name);
        tick(0, 2'b00, 5'd0, 0, 0, 0, 1, sel);
        idle();
        check(name, 32'(rd_data0), 32'(exp));
        check({name, " rd_valid"}, 32'(rd_valid0), 32'd1);
    endtask

    int exp1 [6] = '{7, 4, 2, 0, 1, 1};

    initial begin
        // Reset
        #2 rst = 1'b1;
        #1 chk_en = 1'b1;
        check("reset rd_valid", 32'(rd_valid0), 32'd0);
        check("reset rd_data",  32'(rd_data0),  32'd0);
        check("reset ovf",      32'(ovf1),      32'd0);
        @(negedge clk); #1 rst = 1'b0;

        // Basic classification, back-to-back reads
        do_clear();
        for (int i = 0; i < 3; i++) instr(2'b01, 5'b00000);
        instr(2'b00, 5'd3); instr(2'b00, 5'd9);
        instr(2'b10, 5'd1);
        instr(2'b11, 5'b00000);
        do_snap();
        for (int i = 0; i < 6; i++) begin
            tick(0, 2'b00, 5'd0, 0, 0, 0, 1, 3'(i));
            if (i > 0) begin
                check($sformatf("basic cnt%0d", i - 1), 32'(rd_data0), 32'(exp1[i-1]));
                check("basic rd_valid", 32'(rd_valid0), 32'd1);
            end
        end
        idle();
        check("basic cnt5", 32'(rd_data0), 32'(exp1[5]));
        idle();
        check("rd_valid drops", 32'(rd_valid0), 32'd0);

        // Stall / illegal decoding, invalid strobe ignored
        do_clear();
        instr(2'b01, 5'b00101); instr(2'b01, 5'b00110); instr(2'b01, 5'b00111);
        instr(2'b01, 5'b01010);
        tick(0, 2'b01, 5'b00000, 0, 0, 0, 0, 3'd0);
        do_snap();
        rd_chk(3'd3, 3, "stall STALL");
        rd_chk(3'd6, 1, "stall ILLEGAL");
        rd_chk(3'd0, 4, "stall INSTR");
        rd_chk(3'd1, 0, "stall ARITH");

        // Overflow: wrap vs saturate on the narrow instances
        do_clear();
        for (int i = 0; i < 17; i++) instr(2'b00, 5'd0);
        do_snap();
        rd_chk(3'd2, 17, "ovf MEM wide");
        check("ovf MEM wrap",  32'(rd_data1), 32'd1);
        check("ovf MEM sat",   32'(rd_data2), 32'd15);
        check("ovf2 wrap",     32'(ovf1[2]),  32'd1);
        check("ovf2 sat",      32'(ovf2[2]),  32'd1);
        check("ovf2 wide",     32'(ovf0[2]),  32'd0);
        do_clear();
        idle();
        check("clear ovf wrap", 32'(ovf1), 32'd0);
        check("clear ovf sat",  32'(ovf2), 32'd0);
        do_snap();
        rd_chk(3'd2, 0, "clear MEM");

        // clear drops same-cycle event; snap+clear captures pre-clear values
        tick(1, 2'b01, 5'b00000, 0, 1, 0, 0, 3'd0);
        do_snap();
        rd_chk(3'd0, 0, "clr-drop INSTR");
        rd_chk(3'd1, 0, "clr-drop ARITH");
        for (int i = 0; i < 5; i++) instr(2'b01, 5'b10011);
        tick(0, 2'b00, 5'd0, 0, 1, 1, 0, 3'd0);
        rd_chk(3'd0, 5, "snap+clear INSTR");

        // Freeze holds everything, release resumes
        do_clear();
        for (int i = 0; i < 3; i++) instr(2'b10, 5'd0);
        for (int i = 0; i < 10; i++) tick(1, 2'b01, 5'd0, 1, 0, (i == 9), 0, 3'd0);
        rd_chk(3'd0, 3, "freeze INSTR");
        rd_chk(3'd7, 3, "freeze CYCLE");
        instr(2'b10, 5'd0); instr(2'b10, 5'd0);
        do_snap();
        rd_chk(3'd0, 5, "resume INSTR");

        // Asynchronous reset mid-stream kills a pending read
        do_clear();
        for (int i = 0; i < 20; i++) instr(2'b01, 5'd0);
        tick(0, 2'b00, 5'd0, 0, 0, 0, 1, 3'd0);
        tick(0, 2'b00, 5'd0, 0, 0, 0, 1, 3'd0);
        #2 rst = 1'b1;
        #1;
        check("arst rd_valid", 32'(rd_valid0), 32'd0);
        check("arst rd_data",  32'(rd_data0),  32'd0);
        check("arst ovf wrap", 32'(ovf1),      32'd0);
        check("arst ovf wide", 32'(ovf0),      32'd0);
        @(negedge clk); #1;
        rst = 1'b0; rd_en = 1'b0;
        idle();
        check("arst no rd_valid", 32'(rd_valid0), 32'd0);
        do_snap();
        rd_chk(3'd0, 0, "arst INSTR");
        idle();
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
